similarity_argmax: RTL
======================

Name: similarity_argmax

Overview:
- Downstream stage of the cosine-similarity engine. It consumes the stream of per-class float32 similarity scores for one query sweep.
- Tracks the best and second-best class with a combinational total-order float compare, so no FP IP is needed.
- Presents one result record per sweep to the classifier controller over a valid/ready handshake.

Parameters:
HV_DATA_WIDTH, 32, score width; IEEE-754 single precision; only 32 is supported
IDX_WIDTH, 4, class index width (up to 16 classes)
CNT_WIDTH, 8, width of the per-sweep accepted-score counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
sim_valid  in  1  score beat present
sim_first  in  1  beat is first of a sweep
sim_last  in  1  beat is last of a sweep
sim_index  in  IDX_WIDTH  class index of the beat
sim_data  in  HV_DATA_WIDTH  float32 similarity score
sim_ready  out  1  block can accept a beat
result_valid  out  1  result record held
result_ready  in  1  downstream takes the record
best_index  out  IDX_WIDTH  index of highest score
best_score  out  HV_DATA_WIDTH  highest score
second_index  out  IDX_WIDTH  index of second-highest score
second_score  out  HV_DATA_WIDTH  second-highest score
result_count  out  CNT_WIDTH  non-NaN scores accepted in the sweep
nan_seen  out  1  at least one NaN beat occurred in the sweep
proto_err  out  1  sticky framing error; cleared only by reset

Behaviour:
- Single clock domain. The only reset is `reset`: synchronous, active-high, sampled on the rising edge of `clk`.
- Reset values:
  - state=S_IDLE; sim_ready=1; result_valid=0.
  - best/second scores = 0xFF800000 (-inf); best/second indices = all ones.
  - result_count=0; nan_seen=0; proto_err=0.
- A reset asserted mid-sweep or while a result is held discards all state the same cycle.
- Beat accepted iff sim_valid && sim_ready.
- Compare key (unsigned compare of 32-bit keys):
  - Normalise -0 (0x80000000) to +0 first.
  - sign=0 → key = x ^ 0x80000000.
  - sign=1 → key = ~x.
- NaN (exp=0xFF, mantissa≠0):
  - Never enters the ranking and is not counted.
  - Sets nan_seen.
  - A NaN beat carrying first/last still frames the sweep.
- Ranking update on an accepted non-NaN beat:
  - key(new) > key(best): second ← best, best ← new.
  - Else if key(new) > key(second): second ← new.
  - Ties keep the earlier beat (strict greater-than).
- result_count increments per non-NaN beat and saturates at 2^CNT_WIDTH-1.
- S_IDLE (sim_ready=1, result_valid=0):
  - Accepted beat with sim_first clears ranking, count and nan_seen, then applies the beat.
  - sim_last also set → S_RESULT; otherwise → S_ACCUM.
  - Accepted beat without sim_first is dropped and sets proto_err.
- S_ACCUM (sim_ready=1):
  - Beats update the ranking. A beat with sim_last → S_RESULT.
  - A beat with sim_first sets proto_err and restarts the sweep with that beat (clear then apply). If it also carries sim_last → S_RESULT.
- S_RESULT:
  - sim_ready=0; result_valid=1.
  - All result outputs are stable while result_valid=1 && result_ready=0.
  - On result_ready=1 → S_IDLE the next cycle with sim_ready=1. Result outputs keep their values until the next sweep's first beat.
- Latency: result_valid rises on the cycle after the last beat is accepted.
- Minimum sweep turnaround: last beat, result cycle, then next first beat (with result_ready held 1).
- Sweep with only NaN beats: result reports count=0, scores -inf, indices all ones, nan_seen=1.
- Result outputs change only on accepted beats or reset.

Test Plan:
- Sweep idx0..3 = 0x3F000000 (0.5), 0x3F666666 (0.9), 0xBE99999A (-0.3), 0x3F333333 (0.7), first on idx0, last on idx3, result_ready=1 → one cycle later result_valid=1; best=1/0x3F666666; second=3/0x3F333333; count=4; nan_seen=0.
- Single beat with first&last, idx5 = 0xBF800000 (-1.0) → best=5/0xBF800000; second=15/0xFF800000; count=1.
- Scores 0x3F000000 idx2, then 0x7FC00000 (NaN) idx3, then 0x3F000000 idx4 (last) → best=2 (tie keeps earlier); second=4; count=2; nan_seen=1.
- Zero/sign ordering: 0x80000000 idx0, 0x00000000 idx1, 0xBF000000 idx2 (last) → best=0 (-0 equals +0, tie keeps earlier); second=1.
- Backpressure: hold result_ready=0 for 5 cycles after last → sim_ready=0 and outputs stable all 5 cycles; beats driven meanwhile are not accepted; on result_ready=1, S_IDLE next cycle.
- Framing: beat without first in idle → dropped, proto_err=1; first mid-sweep → sweep restarts; reset asserted during S_RESULT → result_valid=0, proto_err=0, sim_ready=1 on the next cycle.

Source files
------------

// File: rtl/similarity_argmax.sv
// similarity_argmax: tracks best/second-best float32 class scores per sweep and hands one result record downstream
module similarity_argmax #(
    parameter int HV_DATA_WIDTH = 32,
    parameter int IDX_WIDTH     = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sim_valid,
    input  logic                     sim_first,
    input  logic                     sim_last,
    input  logic [IDX_WIDTH-1:0]     sim_index,
    input  logic [HV_DATA_WIDTH-1:0] sim_data,
    output logic                     sim_ready,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [IDX_WIDTH-1:0]     best_index,
    output logic [HV_DATA_WIDTH-1:0] best_score,
    output logic [IDX_WIDTH-1:0]     second_index,
    output logic [HV_DATA_WIDTH-1:0] second_score,
    output logic [CNT_WIDTH-1:0]     result_count,
    output logic                     nan_seen,
    output logic                     proto_err
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESULT} state_t;

    localparam logic [HV_DATA_WIDTH-1:0] MSB_ONLY = {1'b1, {(HV_DATA_WIDTH-1){1'b0}}};
    localparam logic [HV_DATA_WIDTH-1:0] NEG_INF  = HV_DATA_WIDTH'(32'hFF80_0000);

    // Maps a float onto an unsigned key whose order is the float total order, with -0 folded onto +0
    function automatic logic [HV_DATA_WIDTH-1:0] order_key(input logic [HV_DATA_WIDTH-1:0] x);
        logic [HV_DATA_WIDTH-1:0] n;
        n = (x == MSB_ONLY) ? '0 : x;
        return n[HV_DATA_WIDTH-1] ? ~n : (n ^ MSB_ONLY);
    endfunction

    state_t                   state, state_next;
    logic                     accept, restart, apply, is_nan, beats_best, beats_second;
    logic [IDX_WIDTH-1:0]     base_best_index, base_second_index, best_index_next, second_index_next;
    logic [HV_DATA_WIDTH-1:0] base_best_score, base_second_score, best_score_next, second_score_next;
    logic [CNT_WIDTH-1:0]     base_count, count_next;
    logic                     nan_next, proto_err_next;

    assign accept  = sim_valid && sim_ready;
    assign restart = accept && sim_first;
    assign apply   = accept && (sim_first || state == S_ACCUM);
    assign is_nan  = (&sim_data[30:23]) && (|sim_data[22:0]);

    // FSM next state and handshake outputs
    always_comb begin
        state_next   = state;
        sim_ready    = state != S_RESULT;
        result_valid = state == S_RESULT;
        case (state)
            S_IDLE:   if (restart) state_next = sim_last ? S_RESULT : S_ACCUM;
            S_ACCUM:  if (accept && sim_last) state_next = S_RESULT;
            S_RESULT: if (result_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Ranking update: a first beat starts from a cleared record, otherwise from the held one
    always_comb begin
        base_best_score   = restart ? NEG_INF : best_score;
        base_best_index   = restart ? '1 : best_index;
        base_second_score = restart ? NEG_INF : second_score;
        base_second_index = restart ? '1 : second_index;
        base_count        = restart ? '0 : result_count;
        beats_best        = order_key(sim_data) > order_key(base_best_score);
        beats_second      = order_key(sim_data) > order_key(base_second_score);
        best_score_next   = base_best_score;
        best_index_next   = base_best_index;
        second_score_next = base_second_score;
        second_index_next = base_second_index;
        count_next        = base_count;
        nan_next          = restart ? 1'b0 : nan_seen;
        proto_err_next    = proto_err | (accept && (sim_first ? state == S_ACCUM : state == S_IDLE));
        if (apply && is_nan) nan_next = 1'b1;
        if (apply && !is_nan) begin
            count_next = (base_count == '1) ? base_count : base_count + 1'b1;
            if (beats_best) begin
                second_score_next = base_best_score;
                second_index_next = base_best_index;
                best_score_next   = sim_data;
                best_index_next   = sim_index;
            end else if (beats_second) begin
                second_score_next = sim_data;
                second_index_next = sim_index;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Result record registers
    always_ff @(posedge clk) begin
        if (reset) begin
            best_score   <= NEG_INF;
            best_index   <= '1;
            second_score <= NEG_INF;
            second_index <= '1;
            result_count <= '0;
            nan_seen     <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            best_score   <= best_score_next;
            best_index   <= best_index_next;
            second_score <= second_score_next;
            second_index <= second_index_next;
            result_count <= count_next;
            nan_seen     <= nan_next;
            proto_err    <= proto_err_next;
        end
    end
endmodule
